// File: rtl/stopwatch_ctrl_if.sv
// Button/counter-chain signal bundle for stopwatch_ctrl.
// master = button/digit-chain side, slave = the controller.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic       mode;
    logic       cnt_tc;
    logic       cnt_ce;
    logic       cnt_ud;
    logic       cnt_clr;
    logic       running;
    logic       lap_hold;
    logic       done;
    logic [1:0] state;

    modport master (
        output btn_ss, btn_lap, btn_clr, mode, cnt_tc,
        input  cnt_ce, cnt_ud, cnt_clr, running, lap_hold, done, state
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, mode, cnt_tc,
        output cnt_ce, cnt_ud, cnt_clr, running, lap_hold, done, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer and tick prescaler for the stopwatch BCD digit chain.
// Optional lap display freeze is built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl #(
    parameter int DIV = 1000000
) (
    input  logic             clk,
    input  logic             rst_n,
    stopwatch_ctrl_if.slave  sw
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          ce_q, ce_d;
    logic          ud_q, ud_d;
    logic          clr_q, clr_d;
    logic          done_q, done_d;
    logic          advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            ce_q    <= 1'b0;
            ud_q    <= 1'b1;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ce_q    <= ce_d;
            ud_q    <= ud_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ce_d    = 1'b0;
        ud_d    = ud_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        advance = 1'b0;

        if (sw.btn_clr) begin
            state_d = IDLE;
            pre_d   = '0;
            clr_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sw.btn_ss) begin
                        ud_d  = sw.mode;
                        pre_d = '0;
                        if (!sw.mode && sw.cnt_tc) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (sw.btn_ss) state_d = PAUSE;
                    else           advance = 1'b1;
                end
                PAUSE: begin
                    // The resume edge counts as a run cycle so pause/resume never shifts tick phase.
                    if (sw.btn_ss) begin
                        state_d = RUN;
                        advance = 1'b1;
                    end
                end
                DONE: ;
                default: state_d = IDLE;
            endcase

            if (advance) begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (!ud_q && sw.cnt_tc) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        ce_d = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_hold_q, lap_hold_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lap_hold_q <= 1'b0;
        else        lap_hold_q <= lap_hold_d;
    end

    always_comb begin
        lap_hold_d = lap_hold_q;
        if (sw.btn_clr || state_d == DONE) begin
            lap_hold_d = 1'b0;
        end else if (sw.btn_lap) begin
            if (state_q == RUN)        lap_hold_d = ~lap_hold_q;
            else if (state_q == PAUSE) lap_hold_d = 1'b0;
        end
    end

    assign sw.lap_hold = lap_hold_q;
`else
    assign sw.lap_hold = 1'b0;
`endif

    assign sw.cnt_ce  = ce_q;
    assign sw.cnt_ud  = ud_q;
    assign sw.cnt_clr = clr_q;
    assign sw.done    = done_q;
    assign sw.running = (state_q == RUN);
    assign sw.state   = state_q;
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run/pause/clear sequencer for the digital stopwatch's cascaded BCD digit counters. It divides the system clock into a one-cycle count-enable tick and drives the digit chain's enable, direction and clear. It stops a countdown at zero and optionally provides a lap (split) display freeze. It sits between the debounced push-button pulses and the digit-counter chain / display mux.

## Interface
- DIV, 1000000, system clocks per count tick (must be ≥ 2); prescaler width is $clog2(DIV)
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- btn_ss  input  1  start/stop request, one-cycle pulse (debounced upstream)
- btn_lap  input  1  lap request, one-cycle pulse
- btn_clr  input  1  clear request, one-cycle pulse
- mode  input  1  1 = count up, 0 = count down; sampled only on start from IDLE
- cnt_tc  input  1  AND of all digit ripple-carry outputs (down mode: display is all zeros)
- cnt_ce  output  1  registered one-cycle count-enable tick to the digit chain
- cnt_ud  output  1  registered direction to the digit chain
- cnt_clr  output  1  registered one-cycle synchronous clear to the digit chain
- running  output  1  high while in RUN
- lap_hold  output  1  display freeze request to the display mux
- done  output  1  one-cycle pulse when a countdown reaches zero
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3

## Operation
- Reset values: state=IDLE, prescaler=0, cnt_ce=0, cnt_ud=1, cnt_clr=0, running=0, lap_hold=0, done=0.
- Priority per cycle: btn_clr, then btn_ss, then btn_lap. btn_ss and btn_lap in the same cycle are both acted on.
- btn_clr in any state:
  - next state IDLE, prescaler=0, lap_hold=0
  - cnt_clr high for exactly one cycle; any tick due that cycle is suppressed
- IDLE:
  - btn_ss latches cnt_ud<=mode and clears the prescaler.
  - If mode=0 and cnt_tc=1, go to DONE and pulse done. No cnt_ce is ever issued.
  - Otherwise go to RUN.
- RUN:
  - Prescaler counts 0..DIV-1 and wraps.
  - When the prescaler is at DIV-1 and no btn_ss/btn_clr is present, a tick is due.
  - Due tick with cnt_ud=1: cnt_ce pulses. The up count wraps freely at all-nines; cnt_tc is ignored.
  - Due tick with cnt_ud=0 and cnt_tc=0: cnt_ce pulses.
  - Due tick with cnt_ud=0 and cnt_tc=1: cnt_ce is suppressed, state goes to DONE, done pulses.
  - btn_ss: go to PAUSE. The prescaler holds its value and no tick is issued that cycle.
- PAUSE:
  - Prescaler frozen.
  - btn_ss returns to RUN and resumes from the held prescaler value.
  - mode is ignored.
- DONE:
  - No ticks; btn_ss and btn_lap are ignored.
  - Only btn_clr leaves DONE.
- cnt_ud changes only on the IDLE→RUN/DONE transition.

## Timing
- btn_ss sampled at edge 0 (IDLE→RUN): the first cnt_ce is high in the cycle after edge DIV. Subsequent ticks are spaced exactly DIV cycles apart while in RUN.
- Pause/resume preserves phase: total RUN cycles between consecutive ticks always equals DIV.
- cnt_tc is sampled when the prescaler is at DIV-1. It reflects the digit state after the previous tick, because the digits update one cycle after cnt_ce and DIV ≥ 2.
- done, cnt_ce and cnt_clr are registered, one cycle wide, and never high in the same cycle.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronously).

## Configuration
- STOPWATCH_LAP_EN defined:
  - In RUN, btn_lap toggles lap_hold; the counters keep running underneath.
  - In PAUSE, btn_lap clears lap_hold only if it is set.
  - lap_hold is cleared by btn_clr and on entry to DONE.
- STOPWATCH_LAP_EN undefined: btn_lap is ignored, lap_hold is tied to 0, and no lap logic is generated.

## Test plan
- DIV=4, up count:
  - Stimulus: reset, mode=1, btn_ss at edge 0.
  - Response: cnt_ud=1; cnt_ce high in cycles after edges 4, 8, 12; running=1.
- DIV=4, pause/resume phase:
  - Stimulus: btn_ss at edge 0, btn_ss at edge 6 (pause), wait 10 cycles, btn_ss at edge 16.
  - Response: ticks after edges 4 and 18; no cnt_ce while state=2.
- DIV=4, countdown to zero:
  - Stimulus: mode=0, model counter preloaded to 0002, start.
  - Response: two cnt_ce pulses. At the third due tick cnt_tc=1, so cnt_ce is suppressed, done pulses once and state=3; later btn_ss has no effect.
- Start with display already at zero:
  - Stimulus: mode=0, cnt_tc=1, btn_ss.
  - Response: state=3 after one edge, done pulses, zero cnt_ce.
- Clear priority:
  - Stimulus: btn_clr and btn_ss in the same cycle the prescaler is at DIV-1 in RUN.
  - Response: state=0, cnt_clr pulses once, no cnt_ce, lap_hold=0.
- Lap (STOPWATCH_LAP_EN defined):
  - Stimulus: btn_lap in RUN.
  - Response: lap_hold=1 while cnt_ce keeps ticking; a second btn_lap clears it.
  - Build without the macro: lap_hold stays 0.
